// File: rtl/lcd_bus_monitor.sv
// lcd_bus_monitor: passive receiver for a KS0108-style LCD bus.
// Synchronizes the bus, decodes each transfer on the falling edge of lcd_e,
// keeps per-half display state and a shadow display RAM readable by the host.
module lcd_bus_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lcd_rst,
    input  logic                 lcd_e,
    input  logic                 lcd_di,
    input  logic                 lcd_rw,
    input  logic [1:0]           lcd_cs,
    input  logic [7:0]           lcd_d,
    input  logic [9:0]           rd_addr,
    output logic [7:0]           rd_data,
    output logic [1:0]           disp_on,
    output logic [5:0]           start_line0,
    output logic [5:0]           start_line1,
    output logic [CNT_WIDTH-1:0] wr_count,
    output logic                 cmd_strobe,
    output logic                 frame_done,
    output logic                 err_read,
    output logic                 err_cmd
);

    // Bus bundle layout: {rst_n, e, di, rw, cs[1:0], d[7:0]}
    localparam int BW = 14;

    typedef enum logic [2:0] {
        CMD_ON,
        CMD_Y,
        CMD_X,
        CMD_START,
        CMD_BAD
    } cmd_e;

    logic [SYNC_STAGES-1:0][BW-1:0] sync_q, sync_d;
    logic [BW-1:0]                  bus_cur;
    logic [BW-2:0]                  bus_prev_q, bus_prev_d;

    logic       panel_run, e_sync, e_prev;
    logic       bus_di, bus_rw;
    logic [1:0] bus_cs;
    logic [7:0] bus_d;
    logic       xfer;
    cmd_e       cmd_kind;

    logic [1:0][2:0] x_q, x_d;
    logic [1:0][5:0] y_q, y_d;
    logic [1:0]      on_q, on_d;
    logic [1:0][5:0] start_q, start_d;

    logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d;
    logic cmd_strobe_q, cmd_strobe_d;
    logic frame_done_q, frame_done_d;
    logic err_read_q, err_read_d;
    logic err_cmd_q, err_cmd_d;
    logic [7:0] rd_data_q, rd_data_d;

    logic [1:0]      we;
    logic [1:0][8:0] waddr;

    // One 512-byte array per half so a dual-select write is two single-port writes
    logic [7:0] mem0 [512];
    logic [7:0] mem1 [512];

    // Synchronizer chain input and shift; the stage before the edge is kept for decode
    always_comb begin
        sync_d = sync_q;
        sync_d[0] = {lcd_rst, lcd_e, lcd_di, lcd_rw, lcd_cs, lcd_d};
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        bus_cur    = sync_q[SYNC_STAGES-1];
        bus_prev_d = bus_cur[BW-2:0];
    end

    // Synchronizer and edge-detect registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            bus_prev_q <= '0;
        end else begin
            sync_q     <= sync_d;
            bus_prev_q <= bus_prev_d;
        end
    end

    assign panel_run = bus_cur[13];
    assign e_sync    = bus_cur[12];
    assign e_prev    = bus_prev_q[12];
    assign bus_di    = bus_prev_q[11];
    assign bus_rw    = bus_prev_q[10];
    assign bus_cs    = bus_prev_q[9:8];
    assign bus_d     = bus_prev_q[7:0];

    // Classify the instruction byte
    always_comb begin
        cmd_kind = CMD_BAD;
        if (bus_d[7:1] == 7'b0011111)    cmd_kind = CMD_ON;
        else if (bus_d[7:6] == 2'b01)    cmd_kind = CMD_Y;
        else if (bus_d[7:3] == 5'b10111) cmd_kind = CMD_X;
        else if (bus_d[7:6] == 2'b11)    cmd_kind = CMD_START;
    end

    // Transfer decode: next per-half state, RAM write enables, counter and pulses
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        on_d         = on_q;
        start_d      = start_q;
        wr_count_d   = wr_count_q;
        cmd_strobe_d = 1'b0;
        frame_done_d = 1'b0;
        err_read_d   = 1'b0;
        err_cmd_d    = 1'b0;
        we           = '0;
        for (int unsigned h = 0; h < 2; h++) begin
            waddr[h] = {x_q[h], y_q[h]};
        end

        xfer = e_prev && !e_sync && !rst && (bus_cs != 2'b00);

        if (!panel_run) begin
            x_d     = '0;
            y_d     = '0;
            on_d    = '0;
            start_d = '0;
        end else if (xfer) begin
            if (bus_rw) begin
                err_read_d = 1'b1;
            end else if (bus_di) begin
                for (int unsigned h = 0; h < 2; h++) begin
                    if (bus_cs[h]) begin
                        we[h]  = 1'b1;
                        y_d[h] = y_q[h] + 6'd1;
                    end
                end
                if (wr_count_q != '1) begin
                    wr_count_d = wr_count_q + CNT_WIDTH'(1);
                end
                if (bus_cs[1] && x_q[1] == 3'd7 && y_q[1] == 6'd63) begin
                    frame_done_d = 1'b1;
                end
            end else begin
                cmd_strobe_d = (cmd_kind != CMD_BAD);
                err_cmd_d    = (cmd_kind == CMD_BAD);
                for (int unsigned h = 0; h < 2; h++) begin
                    if (bus_cs[h]) begin
                        case (cmd_kind)
                            CMD_ON:    on_d[h]    = bus_d[0];
                            CMD_Y:     y_d[h]     = bus_d[5:0];
                            CMD_X:     x_d[h]     = bus_d[2:0];
                            CMD_START: start_d[h] = bus_d[5:0];
                            default:   ;
                        endcase
                    end
                end
            end
        end
    end

    // Per-half state, counter, pulses and host read data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            on_q         <= '0;
            start_q      <= '0;
            wr_count_q   <= '0;
            cmd_strobe_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_read_q   <= 1'b0;
            err_cmd_q    <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            on_q         <= on_d;
            start_q      <= start_d;
            wr_count_q   <= wr_count_d;
            cmd_strobe_q <= cmd_strobe_d;
            frame_done_q <= frame_done_d;
            err_read_q   <= err_read_d;
            err_cmd_q    <= err_cmd_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Host read mux; registered above, so a same-cycle bus write returns the old byte
    always_comb begin
        rd_data_d = rd_addr[9] ? mem1[rd_addr[8:0]] : mem0[rd_addr[8:0]];
    end

    // Shadow RAM writes, not affected by any reset
    always_ff @(posedge clk) begin
        if (we[0]) mem0[waddr[0]] <= bus_d;
        if (we[1]) mem1[waddr[1]] <= bus_d;
    end

    assign rd_data     = rd_data_q;
    assign disp_on     = on_q;
    assign start_line0 = start_q[0];
    assign start_line1 = start_q[1];
    assign wr_count    = wr_count_q;
    assign cmd_strobe  = cmd_strobe_q;
    assign frame_done  = frame_done_q;
    assign err_read    = err_read_q;
    assign err_cmd     = err_cmd_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed testbench for lcd_bus_monitor.
module tb_lcd_bus_monitor;

    logic        clk = 1'b0;
    logic        rst, lcd_rst, lcd_e, lcd_di, lcd_rw;
    logic [1:0]  lcd_cs;
    logic [7:0]  lcd_d;
    logic [9:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [1:0]  disp_on;
    logic [5:0]  start_line0, start_line1;
    logic [15:0] wr_count;
    logic        cmd_strobe, frame_done, err_read, err_cmd;

    int tests = 0;
    int fails = 0;
    int n_cmd = 0, n_fd = 0, n_er = 0, n_ec = 0;

    lcd_bus_monitor #(.SYNC_STAGES(2), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .lcd_rst(lcd_rst), .lcd_e(lcd_e),
        .lcd_di(lcd_di), .lcd_rw(lcd_rw), .lcd_cs(lcd_cs), .lcd_d(lcd_d),
        .rd_addr(rd_addr), .rd_data(rd_data), .disp_on(disp_on),
        .start_line0(start_line0), .start_line1(start_line1),
        .wr_count(wr_count), .cmd_strobe(cmd_strobe), .frame_done(frame_done),
        .err_read(err_read), .err_cmd(err_cmd)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse output, sampled away from the active edge
    always @(negedge clk) begin
        if (cmd_strobe) n_cmd++;
        if (frame_done) n_fd++;
        if (err_read)   n_er++;
        if (err_cmd)    n_ec++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic di, input logic rw, input logic [1:0] cs, input logic [7:0] d);
        @(negedge clk);
        lcd_di = di; lcd_rw = rw; lcd_cs = cs; lcd_d = d; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic instr(input logic [1:0] cs, input logic [7:0] d);
        xfer(1'b0, 1'b0, cs, d);
    endtask

    task automatic dwr(input logic [1:0] cs, input logic [7:0] d);
        xfer(1'b1, 1'b0, cs, d);
    endtask

    task automatic host_rd(input logic [9:0] a, output logic [7:0] v);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        v = rd_data;
    endtask

    function automatic logic [7:0] rom(input int h, input int p, input int y);
        return 8'(h * 157 + p * 29 + y * 7 + 60) ^ 8'(y * y);
    endfunction

    initial begin
        logic [7:0]  v, at_w, after;
        logic [15:0] wc_before;
        int s_cmd, s_fd, s_er, s_ec;
        int exp_wr;
        int bad;
        bit seen;

        rst = 1'b1; lcd_rst = 1'b1; lcd_e = 1'b0; lcd_di = 1'b0; lcd_rw = 1'b0;
        lcd_cs = 2'b00; lcd_d = 8'h00; rd_addr = 10'h000;
        exp_wr = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_disp_on", 32'(disp_on), 32'h0);
        chk("rst_start0", 32'(start_line0), 32'h0);
        chk("rst_start1", 32'(start_line1), 32'h0);
        chk("rst_wr_count", 32'(wr_count), 32'h0);
        chk("rst_pulses", 32'({cmd_strobe, frame_done, err_read, err_cmd}), 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_wr_count", 32'(wr_count), 32'h0);
        chk("idle_no_pulses", 32'(n_cmd + n_fd + n_er + n_ec), 32'h0);

        // Instruction decode on the left half
        s_cmd = n_cmd;
        instr(2'b01, 8'h3F);
        instr(2'b01, 8'hBA);
        instr(2'b01, 8'h45);
        instr(2'b01, 8'hC7);
        chk("dec_disp_on", 32'(disp_on), 32'h1);
        chk("dec_start0", 32'(start_line0), 32'd7);
        chk("dec_start1", 32'(start_line1), 32'd0);
        chk("dec_cmd_pulses", 32'(n_cmd - s_cmd), 32'd4);
        dwr(2'b01, 8'h11); exp_wr++;
        host_rd(10'h085, v);
        chk("dec_page2_y5", 32'(v), 32'h11);

        // Right half data writes with y wrap and frame_done
        instr(2'b10, 8'hBF);
        instr(2'b10, 8'h7E);
        s_fd = n_fd;
        dwr(2'b10, 8'hA5); exp_wr++;
        chk("fd_after_w1", 32'(n_fd - s_fd), 32'd0);
        dwr(2'b10, 8'h5A); exp_wr++;
        chk("fd_after_w2", 32'(n_fd - s_fd), 32'd1);
        dwr(2'b10, 8'h3C); exp_wr++;
        chk("fd_after_w3", 32'(n_fd - s_fd), 32'd1);
        chk("wrap_wr_count", 32'(wr_count), 32'(exp_wr));
        chk("right_disp_off", 32'(disp_on), 32'h1);
        host_rd(10'h3FE, v); chk("ram_1_7_62", 32'(v), 32'hA5);
        host_rd(10'h3FF, v); chk("ram_1_7_63", 32'(v), 32'h5A);
        host_rd(10'h3C0, v); chk("ram_1_7_0", 32'(v), 32'h3C);

        // Dual select, errors, ignored transfers
        instr(2'b11, 8'hB8);
        instr(2'b11, 8'h40);
        dwr(2'b11, 8'h81); exp_wr++;
        chk("dual_wr_count", 32'(wr_count), 32'(exp_wr));
        host_rd(10'h000, v); chk("dual_left", 32'(v), 32'h81);
        host_rd(10'h200, v); chk("dual_right", 32'(v), 32'h81);
        s_cmd = n_cmd; s_ec = n_ec; s_er = n_er;
        instr(2'b11, 8'h00);
        chk("err_cmd_00", 32'(n_ec - s_ec), 32'd1);
        instr(2'b11, 8'h3D);
        chk("err_cmd_3d", 32'(n_ec - s_ec), 32'd2);
        chk("err_no_strobe", 32'(n_cmd - s_cmd), 32'd0);
        xfer(1'b1, 1'b1, 2'b11, 8'hFF);
        chk("err_read_pulse", 32'(n_er - s_er), 32'd1);
        chk("read_wr_count", 32'(wr_count), 32'(exp_wr));
        dwr(2'b00, 8'hEE);
        chk("cs00_wr_count", 32'(wr_count), 32'(exp_wr));
        chk("cs00_no_err", 32'((n_er - s_er) + (n_ec - s_ec)), 32'd3);
        dwr(2'b11, 8'h77); exp_wr++;
        host_rd(10'h001, v); chk("after_read_left_y1", 32'(v), 32'h77);
        host_rd(10'h201, v); chk("after_read_right_y1", 32'(v), 32'h77);
        instr(2'b11, 8'h3F);
        instr(2'b11, 8'hC5);
        chk("both_on", 32'(disp_on), 32'h3);
        chk("both_start", 32'({start_line1, start_line0}), 32'({6'd5, 6'd5}));

        // Panel reset mid-stream
        @(negedge clk);
        lcd_rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("prst_disp_on", 32'(disp_on), 32'h0);
        chk("prst_start", 32'({start_line1, start_line0}), 32'h0);
        dwr(2'b11, 8'hEE);
        chk("prst_wr_ignored", 32'(wr_count), 32'(exp_wr));
        lcd_rst = 1'b1;
        repeat (6) @(negedge clk);
        host_rd(10'h3FE, v); chk("prst_keep_a5", 32'(v), 32'hA5);
        host_rd(10'h000, v); chk("prst_keep_81", 32'(v), 32'h81);
        dwr(2'b01, 8'h99); exp_wr++;
        host_rd(10'h000, v); chk("prst_xy_cleared", 32'(v), 32'h99);

        // Read-first: host reads the address being written in the same cycle
        @(negedge clk);
        rd_addr = 10'h001;
        @(negedge clk);
        wc_before = wr_count;
        lcd_di = 1'b1; lcd_rw = 1'b0; lcd_cs = 2'b01; lcd_d = 8'h42; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        seen = 1'b0; at_w = 8'h00; after = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!seen && wr_count != wc_before) begin
                seen = 1'b1;
                at_w = rd_data;
                @(negedge clk);
                after = rd_data;
            end
        end
        exp_wr++;
        chk("rf_write_seen", 32'(seen), 32'd1);
        chk("rf_old_byte", 32'(at_w), 32'h77);
        chk("rf_new_byte", 32'(after), 32'h42);
        chk("pre_frame_wr_count", 32'(wr_count), 32'(exp_wr));

        // Full frame from the ROM image
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("frame_rst_count", 32'(wr_count), 32'd0);
        s_fd = n_fd;
        for (int h = 0; h < 2; h++) begin
            for (int p = 0; p < 8; p++) begin
                instr(2'(1 << h), 8'hB8 | 8'(p));
                instr(2'(1 << h), 8'h40);
                for (int y = 0; y < 64; y++) begin
                    dwr(2'(1 << h), rom(h, p, y));
                end
            end
        end
        chk("frame_wr_count", 32'(wr_count), 32'd1024);
        chk("frame_done_once", 32'(n_fd - s_fd), 32'd1);
        bad = 0;
        for (int a = 0; a < 1024; a++) begin
            host_rd(10'(a), v);
            if (v !== rom(a / 512, (a / 64) % 8, a % 64)) begin
                if (bad == 0) $display("first frame difference at addr %0h: got %0h want %0h",
                                       a, v, rom(a / 512, (a / 64) % 8, a % 64));
                bad++;
            end
        end
        chk("frame_image_diffs", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
